// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types for the two-port SDRAM slot arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arb_state_t (IDLE/BUSY), port_t (PORT_A/PORT_B), SDRAM_AW,
//           req_t bundle of one port's access fields.
package sdram_arb_pkg;

  localparam int SDRAM_AW = 23;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  typedef struct packed {
    logic                we;
    logic [SDRAM_AW-1:0] addr;
    logic [1:0]          bank;
    logic [7:0]          din;
  } req_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// sdram_arb_prio: bounded-starvation fixed-priority grant between ports A and B.
// Latency: grant is combinational; the starvation counter updates on i_upd.
// Backpressure: none; the low port is forced through after MAX_WAIT lost decisions.
// Ports: i_clk, i_rst_n (async active-low), i_a_req, i_b_req, i_upd (a grant
//        decision is being taken this clk), o_grant_vld, o_grant_port.
module sdram_arb_prio
  import sdram_arb_pkg::*;
#(
  parameter int A_HIGH   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_a_req,
  input  logic  i_b_req,
  input  logic  i_upd,
  output logic  o_grant_vld,
  output port_t o_grant_port
);

  localparam port_t      HI_PORT = (A_HIGH != 0) ? PORT_A : PORT_B;
  localparam port_t      LO_PORT = (A_HIGH != 0) ? PORT_B : PORT_A;
  localparam logic [3:0] MAX_W   = 4'(MAX_WAIT);

  logic [3:0] r_wait_cnt;
  logic       w_hi_req;
  logic       w_lo_req;
  logic       w_lo_win;

  assign w_hi_req = (A_HIGH != 0) ? i_a_req : i_b_req;
  assign w_lo_req = (A_HIGH != 0) ? i_b_req : i_a_req;

  // Low port wins when it is alone, or when it has lost MAX_WAIT decisions in a row.
  assign w_lo_win     = w_lo_req & (~w_hi_req | (r_wait_cnt == MAX_W));
  assign o_grant_vld  = i_a_req | i_b_req;
  assign o_grant_port = w_lo_win ? LO_PORT : HI_PORT;

  // Counter only moves when the low port loses a contested decision; any
  // other decision outcome (low granted, or low idle) restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (i_upd) begin
      if (w_hi_req && w_lo_req && !w_lo_win) begin
        if (r_wait_cnt < MAX_W) begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
        end
      end else begin
        r_wait_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: two-port req/ack arbiter feeding one access per clkref slot to the SDRAM controller.
// Latency: access issued at the first clkref rise seen in IDLE, acked at the following rise (2 slots minimum).
// Backpressure: requesters hold req and fields until their one-clk ack; the loser simply waits for a later slot.
// Ports: clk, rst_n (async active-low), clkref; port A/B: *_req, *_we, *_addr[22:0],
//        *_bank[1:0], *_din[7:0] in, *_ack, *_dout[7:0] out; controller: sd_oe, sd_we,
//        sd_addr, sd_bank, sd_din out, sd_dout in.
// Build option: define SDRAM_ARB_WPROT_EN to suppress writes to bank WP_BANK (still acked).
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int A_HIGH   = 1,
  parameter int MAX_WAIT = 4,
  parameter int WP_BANK  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clkref,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [SDRAM_AW-1:0] a_addr,
  input  logic [1:0]          a_bank,
  input  logic [7:0]          a_din,
  output logic                a_ack,
  output logic [7:0]          a_dout,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [SDRAM_AW-1:0] b_addr,
  input  logic [1:0]          b_bank,
  input  logic [7:0]          b_din,
  output logic                b_ack,
  output logic [7:0]          b_dout,
  output logic                sd_oe,
  output logic                sd_we,
  output logic [SDRAM_AW-1:0] sd_addr,
  output logic [1:0]          sd_bank,
  output logic [7:0]          sd_din,
  input  logic [7:0]          sd_dout
);

`ifdef SDRAM_ARB_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif
  localparam logic [1:0] WP_B = 2'(WP_BANK);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  port_t               r_owner;
  logic                r_ref_q;
  logic                w_ref_rise;
  logic                w_start;
  logic                w_finish;
  logic                w_grant_vld;
  port_t               w_grant_port;
  logic                w_wprot;
  req_t                w_a_fields;
  req_t                w_b_fields;
  req_t                w_sel;

  logic                r_a_ack;
  logic                r_b_ack;
  logic [7:0]          r_a_dout;
  logic [7:0]          r_b_dout;
  logic                r_sd_oe;
  logic                r_sd_we;
  logic [SDRAM_AW-1:0] r_sd_addr;
  logic [1:0]          r_sd_bank;
  logic [7:0]          r_sd_din;

  // ref_q resets high so a clkref already high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_q <= 1'b1;
    end else begin
      r_ref_q <= clkref;
    end
  end

  assign w_ref_rise = clkref & ~r_ref_q;

  assign w_a_fields = '{we: a_we, addr: a_addr, bank: a_bank, din: a_din};
  assign w_b_fields = '{we: b_we, addr: b_addr, bank: b_bank, din: b_din};

  sdram_arb_prio #(
    .A_HIGH   (A_HIGH),
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_a_req      (a_req),
    .i_b_req      (b_req),
    .i_upd        (w_ref_rise & (r_state == IDLE)),
    .o_grant_vld  (w_grant_vld),
    .o_grant_port (w_grant_port)
  );

  assign w_sel   = (w_grant_port == PORT_A) ? w_a_fields : w_b_fields;
  // A protected write still occupies its slot pair but drives neither strobe.
  assign w_wprot = WPROT_EN & w_sel.we & (w_sel.bank == WP_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ref_rise && w_grant_vld) begin
          w_start     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_ref_rise) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // sd_addr/bank/din keep the last access after it completes; only strobes drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= PORT_A;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_dout  <= 8'd0;
      r_b_dout  <= 8'd0;
      r_sd_oe   <= 1'b0;
      r_sd_we   <= 1'b0;
      r_sd_addr <= '0;
      r_sd_bank <= 2'd0;
      r_sd_din  <= 8'd0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      if (w_start) begin
        r_owner   <= w_grant_port;
        r_sd_addr <= w_sel.addr;
        r_sd_bank <= w_sel.bank;
        r_sd_din  <= w_sel.din;
        r_sd_oe   <= ~w_sel.we & ~w_wprot;
        r_sd_we   <= w_sel.we & ~w_wprot;
      end
      if (w_finish) begin
        r_sd_oe <= 1'b0;
        r_sd_we <= 1'b0;
        if (r_owner == PORT_A) begin
          r_a_ack  <= 1'b1;
          r_a_dout <= sd_dout;
        end else begin
          r_b_ack  <= 1'b1;
          r_b_dout <= sd_dout;
        end
      end
    end
  end

  assign a_ack   = r_a_ack;
  assign a_dout  = r_a_dout;
  assign b_ack   = r_b_ack;
  assign b_dout  = r_b_dout;
  assign sd_oe   = r_sd_oe;
  assign sd_we   = r_sd_we;
  assign sd_addr = r_sd_addr;
  assign sd_bank = r_sd_bank;
  assign sd_din  = r_sd_din;

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: directed bench for sdram_port_arb with hand-computed expectations.
// Latency: clkref driven by the bench; one edge is taken per rise_edge call.
// Backpressure: n/a (bench drives all handshakes directly).
module tb_sdram_port_arb;

  logic        clk;
  logic        rst_n;
  logic        clkref;
  logic        a_req, a_we, b_req, b_we;
  logic [22:0] a_addr, b_addr;
  logic [1:0]  a_bank, b_bank;
  logic [7:0]  a_din, b_din;
  logic        a_ack, b_ack;
  logic [7:0]  a_dout, b_dout;
  logic        sd_oe, sd_we;
  logic [22:0] sd_addr;
  logic [1:0]  sd_bank;
  logic [7:0]  sd_din, sd_dout;

  int n_checks;
  int n_errors;
  int ack_cnt;

  sdram_port_arb #(
    .A_HIGH   (1),
    .MAX_WAIT (4),
    .WP_BANK  (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clkref  (clkref),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_bank  (a_bank),
    .a_din   (a_din),
    .a_ack   (a_ack),
    .a_dout  (a_dout),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_bank  (b_bank),
    .b_din   (b_din),
    .b_ack   (b_ack),
    .b_dout  (b_dout),
    .sd_oe   (sd_oe),
    .sd_we   (sd_we),
    .sd_addr (sd_addr),
    .sd_bank (sd_bank),
    .sd_din  (sd_din),
    .sd_dout (sd_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (a_ack || b_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise clkref; after return the edge has been taken by the DUT.
  task automatic rise_edge();
    clkref = 1'b1;
    tick();
  endtask

  // Remainder of a slot: clkref high 2 more clks, then low 3 clks.
  task automatic finish_slot();
    tick();
    tick();
    clkref = 1'b0;
    tick();
    tick();
    tick();
  endtask

  string       exp_seq;
  logic [7:0]  got_seq[$];
  logic        seen_oe;
  int          acks_before;

  initial begin
    n_checks = 0;
    n_errors = 0;
    ack_cnt  = 0;
    rst_n    = 1'b0;
    clkref   = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_bank = 2'd0; a_din = 8'd0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_bank = 2'd0; b_din = 8'd0;
    sd_dout = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_sd_oe", 32'(sd_oe), 32'd0);
    check("rst_sd_we", 32'(sd_we), 32'd0);
    check("rst_sd_addr", 32'(sd_addr), 32'd0);
    check("rst_sd_bank_din", {22'd0, sd_bank, sd_din}, 32'd0);
    check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    check("rst_douts", {16'd0, a_dout, b_dout}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Port A read
    sd_dout = 8'hA5;
    a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000100; a_bank = 2'd0;
    tick();
    rise_edge();
    check("rd_oe_on", 32'(sd_oe), 32'd1);
    check("rd_we_off", 32'(sd_we), 32'd0);
    check("rd_addr", 32'(sd_addr), 32'h000100);
    check("rd_no_early_ack", 32'(a_ack), 32'd0);
    finish_slot();
    check("rd_oe_held", 32'(sd_oe), 32'd1);
    rise_edge();
    check("rd_ack", 32'(a_ack), 32'd1);
    check("rd_dout", 32'(a_dout), 32'hA5);
    check("rd_oe_off", 32'(sd_oe), 32'd0);
    check("rd_addr_hold", 32'(sd_addr), 32'h000100);
    a_req = 1'b0;
    tick();
    check("rd_ack_pulse", 32'(a_ack), 32'd0);
    check("rd_dout_hold", 32'(a_dout), 32'hA5);
    finish_slot();
    rise_edge();
    check("idle_slot_oe", {30'd0, sd_oe, sd_we}, 32'd0);
    finish_slot();

    // Port B write
    sd_dout = 8'h5A;
    b_req = 1'b1; b_we = 1'b1; b_addr = 23'h012345; b_din = 8'h3C; b_bank = 2'd1;
    rise_edge();
    check("wr_we_on", 32'(sd_we), 32'd1);
    check("wr_oe_off", 32'(sd_oe), 32'd0);
    check("wr_addr", 32'(sd_addr), 32'h012345);
    check("wr_din", 32'(sd_din), 32'h3C);
    check("wr_bank", 32'(sd_bank), 32'd1);
    finish_slot();
    rise_edge();
    check("wr_ack", {30'd0, a_ack, b_ack}, 32'd1);
    check("wr_we_off", 32'(sd_we), 32'd0);
    check("wr_dout", 32'(b_dout), 32'h5A);
    b_req = 1'b0;
    finish_slot();

    // Both ports held: A wins 4 times, then B is forced through
    a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000100; a_bank = 2'd0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 23'h000200; b_bank = 2'd0;
    for (int i = 0; i < 20; i++) begin
      rise_edge();
      if (a_ack) got_seq.push_back("A");
      if (b_ack) got_seq.push_back("B");
      finish_slot();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    exp_seq = "AAAABAAAAB";
    check("arb_grant_count", 32'(got_seq.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < got_seq.size()) check($sformatf("arb_grant_%0d", i), 32'(got_seq[i]), 32'(exp_seq[i]));
    end
    finish_slot();

    // Reset while BUSY
    a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000100; a_bank = 2'd0;
    rise_edge();
    check("rst_busy_oe_pre", 32'(sd_oe), 32'd1);
    tick();
    acks_before = ack_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_busy_oe_async", 32'(sd_oe), 32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    seen_oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_oe = seen_oe | sd_oe;
    end
    clkref = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_oe = seen_oe | sd_oe;
    end
    check("rst_rel_no_access", 32'(seen_oe), 32'd0);
    check("rst_no_ack", 32'(ack_cnt - acks_before), 32'd0);
    rise_edge();
    check("rst_rel_next_edge", 32'(sd_oe), 32'd1);
    finish_slot();
    rise_edge();
    check("rst_rereq_ack", 32'(a_ack), 32'd1);
    a_req = 1'b0;
    finish_slot();

    // Request raised mid-slot: no issue until the next edge
    rise_edge();
    a_req = 1'b1; a_addr = 23'h000321;
    seen_oe = 1'b0;
    tick();
    seen_oe = seen_oe | sd_oe;
    tick();
    seen_oe = seen_oe | sd_oe;
    clkref = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_oe = seen_oe | sd_oe;
    end
    check("mid_no_early_oe", 32'(seen_oe), 32'd0);
    rise_edge();
    check("mid_oe_at_edge", 32'(sd_oe), 32'd1);
    check("mid_addr", 32'(sd_addr), 32'h000321);
    finish_slot();
    rise_edge();
    check("mid_ack", 32'(a_ack), 32'd1);
    a_req = 1'b0;
    finish_slot();

    // Write to the protected bank, then to an ordinary bank
    sd_dout = 8'h77;
    a_req = 1'b1; a_we = 1'b1; a_addr = 23'h000400; a_bank = 2'd3; a_din = 8'h11;
    rise_edge();
`ifdef SDRAM_ARB_WPROT_EN
    check("wp_bank3_we", {30'd0, sd_oe, sd_we}, 32'd0);
`else
    check("wp_bank3_we", {30'd0, sd_oe, sd_we}, 32'd1);
`endif
    finish_slot();
    rise_edge();
    check("wp_bank3_ack", 32'(a_ack), 32'd1);
    check("wp_bank3_dout", 32'(a_dout), 32'h77);
    a_req = 1'b0;
    finish_slot();
    a_req = 1'b1; a_bank = 2'd2;
    rise_edge();
    check("wp_bank2_we", {30'd0, sd_oe, sd_we}, 32'd1);
    finish_slot();
    rise_edge();
    check("wp_bank2_ack", 32'(a_ack), 32'd1);
    a_req = 1'b0;
    finish_slot();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
